// File: rtl/vinstr_issue_scheduler_pkg.sv
// Shared types and defaults for the vector instruction issue scheduler.
// - issue_kind_e  : target class of a decoded instruction (ALU / load / store / cfg)
// - issue_entry_t : one issue-queue entry (instruction, tag, kind, operand usage, ALU slot mask)
// - VISSUE_*      : default geometry; the entry layout is sized from these values,
//                   so scheduler instances should keep their width parameters equal to them.
// Optional feature macro used by the scheduler: VISSUE_BYPASS_EN.
package vinstr_issue_scheduler_pkg;

  localparam int VISSUE_QUEUE_DEPTH    = 4;
  localparam int VISSUE_SLOT_COUNT     = 2;
  localparam int VISSUE_INSTR_WIDTH    = 32;
  localparam int VISSUE_TRACK_ID_WIDTH = 4;

  typedef enum logic [1:0] {
    KIND_ALU   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_CFG   = 2'd3
  } issue_kind_e;

  typedef struct packed {
    logic [VISSUE_INSTR_WIDTH-1:0]    instr;
    logic [VISSUE_TRACK_ID_WIDTH-1:0] track_id;
    issue_kind_e                      kind;
    logic                             uses_vs1;
    logic                             uses_vs2;
    logic                             uses_vd;
    logic [VISSUE_SLOT_COUNT-1:0]     alu_compatible;
  } issue_entry_t;

endpackage

// File: rtl/vinstr_issue_scheduler_if.sv
// Signal bundle between the decoder / execution resources and the issue scheduler.
// modport slave  : the scheduler (consumes decoded instructions, drives dispatch ports)
// modport master : the surrounding system (decoder, slots, mem port, cfg unit, writeback)
// Groups: in_* decoded-instruction handshake, slot_* ALU dispatch, mem_* load/store
// dispatch, cfg_* config request/ack, wb_* writeback completion, busy_vregs / queue_count status.
interface vinstr_issue_scheduler_if #(
  parameter int SLOT_COUNT     = 2,
  parameter int QUEUE_DEPTH    = 4,
  parameter int INSTR_WIDTH    = 32,
  parameter int TRACK_ID_WIDTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic                                       in_valid;
  logic                                       in_ready;
  logic [INSTR_WIDTH-1:0]                     in_instr;
  logic [TRACK_ID_WIDTH-1:0]                  in_track_id;
  logic [1:0]                                 in_kind;
  logic                                       in_uses_vs1;
  logic                                       in_uses_vs2;
  logic                                       in_uses_vd;
  logic [SLOT_COUNT-1:0]                      in_alu_compatible;
  logic [SLOT_COUNT-1:0]                      slot_valid;
  logic [SLOT_COUNT-1:0]                      slot_ready;
  logic [SLOT_COUNT-1:0][INSTR_WIDTH-1:0]     slot_instr;
  logic [SLOT_COUNT-1:0][TRACK_ID_WIDTH-1:0]  slot_track_id;
  logic                                       mem_valid;
  logic                                       mem_ready;
  logic [INSTR_WIDTH-1:0]                     mem_instr;
  logic [TRACK_ID_WIDTH-1:0]                  mem_track_id;
  logic                                       cfg_valid;
  logic                                       cfg_ack;
  logic [INSTR_WIDTH-1:0]                     cfg_instr;
  logic [SLOT_COUNT:0]                        wb_done;
  logic [SLOT_COUNT:0][4:0]                   wb_vd;
  logic [31:0]                                busy_vregs;
  logic [CW-1:0]                              queue_count;

  modport slave (
    input  in_valid, in_instr, in_track_id, in_kind, in_uses_vs1, in_uses_vs2, in_uses_vd,
           in_alu_compatible, slot_ready, mem_ready, cfg_ack, wb_done, wb_vd,
    output in_ready, slot_valid, slot_instr, slot_track_id, mem_valid, mem_instr,
           mem_track_id, cfg_valid, cfg_instr, busy_vregs, queue_count
  );

  modport master (
    output in_valid, in_instr, in_track_id, in_kind, in_uses_vs1, in_uses_vs2, in_uses_vd,
           in_alu_compatible, slot_ready, mem_ready, cfg_ack, wb_done, wb_vd,
    input  in_ready, slot_valid, slot_instr, slot_track_id, mem_valid, mem_instr,
           mem_track_id, cfg_valid, cfg_instr, busy_vregs, queue_count
  );
endinterface

// File: rtl/vinstr_issue_scheduler_fifo.sv
// vissue_fifo: synchronous FIFO of issue_entry_t for the issue queue.
// Ports: clk, rst (sync, active-high), push/push_data, pop, head (current oldest entry),
//        count (occupancy), full, empty. Caller guarantees no push when full, no pop when empty.
module vissue_fifo
  import vinstr_issue_scheduler_pkg::*;
#(
  parameter int DEPTH = VISSUE_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  issue_entry_t               push_data,
  input  logic                       pop,
  output issue_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  issue_entry_t         entries [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW:0]          count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible because count gates them.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr_reg] <= push_data;
  end

  // The head must be visible in the cycle after enqueue, so the read is asynchronous
  // (a queue this shallow maps to distributed storage anyway).
  assign head  = entries[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
endmodule

// File: rtl/vinstr_issue_scheduler.sv
// vinstr_issue_scheduler: in-order issue of decoded vector instructions to SLOT_COUNT ALU
// slots, one load/store port and one vector-config port, guarded by a 32-entry
// vector-register busy scoreboard (RAW/WAW on the queue head).
// Ports: clk, rst (sync, active-high), bus (vinstr_issue_scheduler_if.slave) carrying the
//        in_*, slot_*, mem_*, cfg_*, wb_* handshakes plus busy_vregs and queue_count.
// Option: `define VISSUE_BYPASS_EN lets an instruction arriving at an empty queue dispatch
//         in the same cycle (1-edge latency); otherwise every instruction takes 2 edges.
module vinstr_issue_scheduler
  import vinstr_issue_scheduler_pkg::*;
#(
  parameter int SLOT_COUNT     = VISSUE_SLOT_COUNT,
  parameter int QUEUE_DEPTH    = VISSUE_QUEUE_DEPTH,
  parameter int INSTR_WIDTH    = VISSUE_INSTR_WIDTH,
  parameter int TRACK_ID_WIDTH = VISSUE_TRACK_ID_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  vinstr_issue_scheduler_if.slave bus
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int SW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

  issue_entry_t          in_entry, head_entry, cand;
  logic                  cand_valid, fifo_full, fifo_empty, push, pop;
  logic [CW-1:0]         fifo_count;
  logic [4:0]            cand_vd, cand_vs1, cand_vs2;
  logic                  hazard, target_ok, dispatch, slot_found;
  logic [SLOT_COUNT-1:0] slot_valid_vec, alu_cands, slot_grant;
  logic [SW-1:0]         slot_sel, rr_ptr_reg, rr_ptr_next;
  logic [31:0]           busy_reg, busy_next;
  logic                  mem_valid_reg, cfg_valid_reg;
  logic [INSTR_WIDTH-1:0]    mem_instr_reg, cfg_instr_reg;
  logic [TRACK_ID_WIDTH-1:0] mem_track_id_reg;

  always_comb begin
    in_entry                = '0;
    in_entry.instr          = bus.in_instr;
    in_entry.track_id       = bus.in_track_id;
    in_entry.kind           = issue_kind_e'(bus.in_kind);
    in_entry.uses_vs1       = bus.in_uses_vs1;
    in_entry.uses_vs2       = bus.in_uses_vs2;
    in_entry.uses_vd        = bus.in_uses_vd;
    in_entry.alu_compatible = bus.in_alu_compatible;
  end

  vissue_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .push_data(in_entry), .pop(pop),
    .head(head_entry), .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
  );

  // Dispatch candidate: the queue head, or (bypass build only) the incoming
  // instruction when the queue is empty, which keeps issue strictly in order.
  always_comb begin
    cand       = head_entry;
    cand_valid = !fifo_empty;
`ifdef VISSUE_BYPASS_EN
    if (fifo_empty) begin
      cand       = in_entry;
      cand_valid = bus.in_valid;
    end
`else
`endif
  end

  assign cand_vd  = cand.instr[11:7];
  assign cand_vs1 = cand.instr[19:15];
  assign cand_vs2 = cand.instr[24:20];

  // vd field doubles as vs3 (store data source) for stores.
  assign hazard = (cand.uses_vs1 && busy_reg[cand_vs1]) ||
                  (cand.uses_vs2 && busy_reg[cand_vs2]) ||
                  (cand.uses_vd  && busy_reg[cand_vd])  ||
                  ((cand.kind == KIND_STORE) && busy_reg[cand_vd]);

  // Round-robin: rr_ptr_reg is the first slot examined; it moves past each grant.
  always_comb begin
    int idx;
    alu_cands  = cand.alu_compatible & ~slot_valid_vec;
    slot_found = 1'b0;
    slot_sel   = '0;
    idx        = 0;
    for (int k = 0; k < SLOT_COUNT; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= SLOT_COUNT) idx = idx - SLOT_COUNT;
      if (!slot_found && alu_cands[idx]) begin
        slot_found = 1'b1;
        slot_sel   = SW'(idx);
      end
    end
    rr_ptr_next = (int'(slot_sel) == SLOT_COUNT - 1) ? '0 : slot_sel + 1'b1;
  end

  // Config instructions act as a full barrier: everything else must have drained.
  always_comb begin
    target_ok = 1'b0;
    case (cand.kind)
      KIND_ALU:              target_ok = slot_found;
      KIND_LOAD, KIND_STORE: target_ok = !mem_valid_reg;
      default:               target_ok = (busy_reg == '0) && (slot_valid_vec == '0) &&
                                         !mem_valid_reg && !cfg_valid_reg;
    endcase
  end

  assign dispatch = cand_valid && !hazard && target_ok && !cfg_valid_reg;
  assign pop      = dispatch && !fifo_empty;
  // A bypassed instruction (dispatch while empty) never enters the queue.
  assign push     = bus.in_valid && !fifo_full && !(dispatch && fifo_empty);

  // Clears first, then the dispatch set, so a same-cycle set on the same register wins.
  always_comb begin
    busy_next = busy_reg;
    for (int i = 0; i <= SLOT_COUNT; i++) begin
      if (bus.wb_done[i]) busy_next[bus.wb_vd[i]] = 1'b0;
    end
    if (dispatch && cand.uses_vd && (cand.kind != KIND_STORE)) busy_next[cand_vd] = 1'b1;
  end

  for (genvar gi = 0; gi < SLOT_COUNT; gi++) begin : g_slot
    logic                      valid_reg;
    logic [INSTR_WIDTH-1:0]    instr_reg;
    logic [TRACK_ID_WIDTH-1:0] track_id_reg;

    assign slot_grant[gi] = dispatch && (cand.kind == KIND_ALU) && (slot_sel == SW'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg    <= 1'b0;
        instr_reg    <= '0;
        track_id_reg <= '0;
      end else if (slot_grant[gi]) begin
        valid_reg    <= 1'b1;
        instr_reg    <= cand.instr;
        track_id_reg <= cand.track_id;
      end else if (bus.slot_ready[gi]) begin
        valid_reg    <= 1'b0;
      end
    end

    assign slot_valid_vec[gi]    = valid_reg;
    assign bus.slot_valid[gi]    = valid_reg;
    assign bus.slot_instr[gi]    = instr_reg;
    assign bus.slot_track_id[gi] = track_id_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_reg    <= 1'b0;
      mem_instr_reg    <= '0;
      mem_track_id_reg <= '0;
      cfg_valid_reg    <= 1'b0;
      cfg_instr_reg    <= '0;
      busy_reg         <= '0;
      rr_ptr_reg       <= '0;
    end else begin
      if (dispatch && ((cand.kind == KIND_LOAD) || (cand.kind == KIND_STORE))) begin
        mem_valid_reg    <= 1'b1;
        mem_instr_reg    <= cand.instr;
        mem_track_id_reg <= cand.track_id;
      end else if (bus.mem_ready) begin
        mem_valid_reg    <= 1'b0;
      end
      if (dispatch && (cand.kind == KIND_CFG)) begin
        cfg_valid_reg <= 1'b1;
        cfg_instr_reg <= cand.instr;
      end else if (bus.cfg_ack) begin
        cfg_valid_reg <= 1'b0;
      end
      busy_reg <= busy_next;
      if (dispatch && (cand.kind == KIND_ALU)) rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign bus.in_ready     = !fifo_full;
  assign bus.mem_valid    = mem_valid_reg;
  assign bus.mem_instr    = mem_instr_reg;
  assign bus.mem_track_id = mem_track_id_reg;
  assign bus.cfg_valid    = cfg_valid_reg;
  assign bus.cfg_instr    = cfg_instr_reg;
  assign bus.busy_vregs   = busy_reg;
  assign bus.queue_count  = fifo_count;
endmodule

// File: tb/tb_vinstr_issue_scheduler.sv
// Directed bench for vinstr_issue_scheduler (default build: 2-edge issue latency).
module tb_vinstr_issue_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vinstr_issue_scheduler_if #(.SLOT_COUNT(2), .QUEUE_DEPTH(4), .INSTR_WIDTH(32),
                              .TRACK_ID_WIDTH(4)) bus ();

  vinstr_issue_scheduler #(.SLOT_COUNT(2), .QUEUE_DEPTH(4), .INSTR_WIDTH(32),
                           .TRACK_ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] vd, input logic [4:0] vs1,
                                     input logic [4:0] vs2);
    return {7'b0, vs2, vs1, 3'b0, vd, 7'h57};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [3:0] id, input logic [1:0] kind,
                       input logic u1, input logic u2, input logic ud, input logic [1:0] compat);
    bus.in_valid          = 1'b1;
    bus.in_instr          = instr;
    bus.in_track_id       = id;
    bus.in_kind           = kind;
    bus.in_uses_vs1       = u1;
    bus.in_uses_vs2       = u2;
    bus.in_uses_vd        = ud;
    bus.in_alu_compatible = compat;
  endtask

  logic [31:0] ia, ib, ic, id, l0, l1;
  logic [31:0] cf;

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_track_id = '0; bus.in_kind = '0;
    bus.in_uses_vs1 = 1'b0; bus.in_uses_vs2 = 1'b0; bus.in_uses_vd = 1'b0;
    bus.in_alu_compatible = '0; bus.slot_ready = 2'b11; bus.mem_ready = 1'b1;
    bus.cfg_ack = 1'b0; bus.wb_done = '0; bus.wb_vd = '0;
    cf = 32'h0070_7057;
    tick();
    do_reset();

    // Reset state
    chk("rst_in_ready",   64'(bus.in_ready), 64'h1);
    chk("rst_slot_valid", 64'(bus.slot_valid), 64'h0);
    chk("rst_mem_valid",  64'(bus.mem_valid), 64'h0);
    chk("rst_cfg_valid",  64'(bus.cfg_valid), 64'h0);
    chk("rst_busy",       64'(bus.busy_vregs), 64'h0);
    chk("rst_count",      64'(bus.queue_count), 64'h0);
    chk("rst_slot_instr", 64'(bus.slot_instr), 64'h0);
    chk("rst_mem_instr",  64'(bus.mem_instr), 64'h0);

    // Basic: VADD v3,v1,v2 -> slot 0 after 2 edges, then writeback clears busy[3]
    ia = mk(5'd3, 5'd1, 5'd2);
    drive(ia, 4'd1, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11);
    tick();
    bus.in_valid = 1'b0;
    chk("basic_count_e0",  64'(bus.queue_count), 64'h1);
    chk("basic_valid_e0",  64'(bus.slot_valid), 64'h0);
    tick();
    chk("basic_valid_e1",  64'(bus.slot_valid), 64'h1);
    chk("basic_instr",     64'(bus.slot_instr[0]), 64'(ia));
    chk("basic_track",     64'(bus.slot_track_id[0]), 64'h1);
    chk("basic_busy_set",  64'(bus.busy_vregs), 64'h8);
    chk("basic_count_e1",  64'(bus.queue_count), 64'h0);
    tick();
    chk("basic_handshake", 64'(bus.slot_valid), 64'h0);
    bus.wb_done = 3'b001; bus.wb_vd[0] = 5'd3;
    tick();
    bus.wb_done = '0;
    chk("basic_busy_clr",  64'(bus.busy_vregs), 64'h0);

    // RAW: v4<-v1,v2 then v5<-v4,v6; second waits for writeback of v4, goes to slot 1
    do_reset();
    ia = mk(5'd4, 5'd1, 5'd2);
    ib = mk(5'd5, 5'd4, 5'd6);
    drive(ia, 4'd2, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11);
    tick();
    drive(ib, 4'd3, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11);
    tick();
    bus.in_valid = 1'b0;
    chk("raw_a_slot",      64'(bus.slot_valid), 64'h1);
    chk("raw_a_busy",      64'(bus.busy_vregs), 64'h10);
    chk("raw_count",       64'(bus.queue_count), 64'h1);
    tick();
    chk("raw_stall_valid", 64'(bus.slot_valid), 64'h0);
    tick();
    chk("raw_stall_count", 64'(bus.queue_count), 64'h1);
    chk("raw_stall_ready", 64'(bus.in_ready), 64'h1);
    bus.wb_done = 3'b001; bus.wb_vd[0] = 5'd4;
    tick();
    bus.wb_done = '0;
    chk("raw_clr_busy",    64'(bus.busy_vregs), 64'h0);
    chk("raw_clr_valid",   64'(bus.slot_valid), 64'h0);
    tick();
    chk("raw_b_slot1",     64'(bus.slot_valid), 64'h2);
    chk("raw_b_instr",     64'(bus.slot_instr[1]), 64'(ib));
    chk("raw_b_track",     64'(bus.slot_track_id[1]), 64'h3);
    chk("raw_b_busy",      64'(bus.busy_vregs), 64'h20);

    // Full queue: loads to v8..v13 with the mem port stalled
    do_reset();
    bus.mem_ready = 1'b0;
    l0 = mk(5'd8, 5'd0, 5'd0);
    l1 = mk(5'd9, 5'd0, 5'd0);
    drive(l0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    drive(l1, 4'd1, 2'd1, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    chk("full_l0_mem",     64'(bus.mem_valid), 64'h1);
    chk("full_l0_instr",   64'(bus.mem_instr), 64'(l0));
    chk("full_l0_busy",    64'(bus.busy_vregs), 64'h100);
    chk("full_count1",     64'(bus.queue_count), 64'h1);
    for (int k = 10; k <= 12; k++) begin
      drive(mk(5'(k), 5'd0, 5'd0), 4'(k - 8), 2'd1, 1'b0, 1'b0, 1'b1, 2'b00);
      tick();
    end
    chk("full_count4",     64'(bus.queue_count), 64'h4);
    chk("full_in_ready",   64'(bus.in_ready), 64'h0);
    drive(mk(5'd13, 5'd0, 5'd0), 4'd5, 2'd1, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    chk("full_reject",     64'(bus.queue_count), 64'h4);
    chk("full_mem_hold",   64'(bus.mem_instr), 64'(l0));
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("full_mem_hs",     64'(bus.mem_valid), 64'h0);
    chk("full_count_hs",   64'(bus.queue_count), 64'h4);
    tick();
    chk("full_l1_mem",     64'(bus.mem_valid), 64'h1);
    chk("full_l1_instr",   64'(bus.mem_instr), 64'(l1));
    chk("full_count3",     64'(bus.queue_count), 64'h3);
    tick();
    bus.in_valid = 1'b0;
    chk("full_accept",     64'(bus.queue_count), 64'h4);
    chk("full_ready_low",  64'(bus.in_ready), 64'h0);

    // Cfg drain: load v2 outstanding, vsetvli waits for its writeback, then holds to ack
    do_reset();
    bus.mem_ready = 1'b1;
    l0 = mk(5'd2, 5'd0, 5'd0);
    drive(l0, 4'd5, 2'd1, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    drive(cf, 4'd6, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    bus.in_valid = 1'b0;
    chk("cfg_ld_mem",      64'(bus.mem_valid), 64'h1);
    chk("cfg_ld_busy",     64'(bus.busy_vregs), 64'h4);
    tick();
    chk("cfg_wait0",       64'(bus.cfg_valid), 64'h0);
    tick();
    chk("cfg_wait1",       64'(bus.cfg_valid), 64'h0);
    chk("cfg_wait_count",  64'(bus.queue_count), 64'h1);
    bus.wb_done = 3'b100; bus.wb_vd[2] = 5'd2;
    tick();
    bus.wb_done = '0;
    chk("cfg_wb_busy",     64'(bus.busy_vregs), 64'h0);
    chk("cfg_wb_valid",    64'(bus.cfg_valid), 64'h0);
    tick();
    chk("cfg_rise",        64'(bus.cfg_valid), 64'h1);
    chk("cfg_instr",       64'(bus.cfg_instr), 64'(cf));
    ic = mk(5'd9, 5'd1, 5'd2);
    drive(ic, 4'd7, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11);
    tick();
    bus.in_valid = 1'b0;
    chk("cfg_q_count",     64'(bus.queue_count), 64'h1);
    tick();
    chk("cfg_hold",        64'(bus.cfg_valid), 64'h1);
    chk("cfg_q_stall",     64'(bus.slot_valid), 64'h0);
    bus.cfg_ack = 1'b1;
    tick();
    bus.cfg_ack = 1'b0;
    chk("cfg_ack_clr",     64'(bus.cfg_valid), 64'h0);
    chk("cfg_ack_slot",    64'(bus.slot_valid), 64'h0);
    tick();
    chk("cfg_after_slot",  64'(bus.slot_valid), 64'h1);
    chk("cfg_after_instr", 64'(bus.slot_instr[0]), 64'(ic));

    // Collision: load v7 dispatches in the cycle a writeback clears v7 -> stays busy
    do_reset();
    drive(mk(5'd7, 5'd0, 5'd0), 4'd8, 2'd1, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    bus.in_valid = 1'b0;
    bus.wb_done = 3'b100; bus.wb_vd[2] = 5'd7;
    tick();
    bus.wb_done = '0;
    chk("coll_busy",       64'(bus.busy_vregs), 64'h80);
    chk("coll_mem",        64'(bus.mem_valid), 64'h1);

    // Reset mid-stall: A on a stuck slot, three dependents queued
    do_reset();
    bus.slot_ready = 2'b00;
    ia = mk(5'd10, 5'd1, 5'd2);
    ib = mk(5'd11, 5'd10, 5'd3);
    ic = mk(5'd12, 5'd10, 5'd4);
    id = mk(5'd13, 5'd10, 5'd5);
    drive(ia, 4'd9, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11);  tick();
    drive(ib, 4'd10, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11); tick();
    drive(ic, 4'd11, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11); tick();
    drive(id, 4'd12, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11); tick();
    bus.in_valid = 1'b0;
    chk("mid_count",       64'(bus.queue_count), 64'h3);
    chk("mid_slot",        64'(bus.slot_valid), 64'h1);
    chk("mid_busy",        64'(bus.busy_vregs), 64'h400);
    do_reset();
    chk("mid_rst_ready",   64'(bus.in_ready), 64'h1);
    chk("mid_rst_slot",    64'(bus.slot_valid), 64'h0);
    chk("mid_rst_instr",   64'(bus.slot_instr), 64'h0);
    chk("mid_rst_track",   64'(bus.slot_track_id), 64'h0);
    chk("mid_rst_busy",    64'(bus.busy_vregs), 64'h0);
    chk("mid_rst_count",   64'(bus.queue_count), 64'h0);
    chk("mid_rst_cfg",     64'(bus.cfg_instr), 64'h0);

    // Empty-queue latency
    bus.slot_ready = 2'b11;
    drive(mk(5'd14, 5'd1, 5'd2), 4'd13, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11);
    tick();
    bus.in_valid = 1'b0;
`ifdef VISSUE_BYPASS_EN
    chk("lat_bypass",      64'(bus.slot_valid), 64'h1);
`else
    chk("lat_e0",          64'(bus.slot_valid), 64'h0);
    tick();
    chk("lat_e1",          64'(bus.slot_valid), 64'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
